// File: rtl/toast_redirect_ctrl_pkg.sv
// Shared encodings for the PC redirect controller: FSM states and ID branch-op codes.
package toast_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HAZ_WAIT = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_t;

    // ID_branch_op_i: bit1 = JALR (reg-offset), bit0 = JAL/conditional (pc-relative)
    localparam logic [1:0] BR_NONE     = 2'b00;
    localparam logic [1:0] PC_RELATIVE = 2'b01;
    localparam logic [1:0] REG_OFFSET  = 2'b10;

endpackage

// File: rtl/toast_redirect_ctrl_if.sv
// Pipeline-side bundle for the redirect controller; master = pipeline/IF/trap side, slave = controller.
interface toast_redirect_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [1:0]            ID_branch_op_i;
    logic                  ID_is_cond_i;
    logic                  ID_branch_taken_i;
    logic [4:0]            ID_rs1_addr_i;
    logic [4:0]            ID_rs2_addr_i;
    logic [4:0]            EX_rd_addr_i;
    logic                  EX_rd_wr_en_i;
    logic                  EX_mem_rd_i;
    logic [4:0]            MEM_rd_addr_i;
    logic                  MEM_mem_rd_i;
    logic [DATA_WIDTH-1:0] pc_dest_i;
    logic                  trap_req_i;
    logic [DATA_WIDTH-1:0] trap_vec_i;
    logic                  IF_ack_i;
    logic                  pc_redirect_o;
    logic [DATA_WIDTH-1:0] pc_target_o;
    logic                  stall_o;
    logic                  IF_ID_flush_o;
    logic                  ID_EX_flush_o;
    logic [CNT_WIDTH-1:0]  stat_redirects_o;
    logic [CNT_WIDTH-1:0]  stat_stall_cycles_o;

    modport master (
        output ID_branch_op_i, ID_is_cond_i, ID_branch_taken_i, ID_rs1_addr_i, ID_rs2_addr_i,
               EX_rd_addr_i, EX_rd_wr_en_i, EX_mem_rd_i, MEM_rd_addr_i, MEM_mem_rd_i,
               pc_dest_i, trap_req_i, trap_vec_i, IF_ack_i,
        input  pc_redirect_o, pc_target_o, stall_o, IF_ID_flush_o, ID_EX_flush_o,
               stat_redirects_o, stat_stall_cycles_o
    );

    modport slave (
        input  ID_branch_op_i, ID_is_cond_i, ID_branch_taken_i, ID_rs1_addr_i, ID_rs2_addr_i,
               EX_rd_addr_i, EX_rd_wr_en_i, EX_mem_rd_i, MEM_rd_addr_i, MEM_mem_rd_i,
               pc_dest_i, trap_req_i, trap_vec_i, IF_ack_i,
        output pc_redirect_o, pc_target_o, stall_o, IF_ID_flush_o, ID_EX_flush_o,
               stat_redirects_o, stat_stall_cycles_o
    );
endinterface

// File: rtl/toast_redirect_hazard.sv
// Load-use hazard detect on branch/jump source operands (purely combinational).
module toast_redirect_hazard
    import toast_redirect_ctrl_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       is_cond,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_rd_wr_en,
    input  logic       ex_mem_rd,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_mem_rd,
    output logic       hazard
);
    logic rs1_hit;
    logic rs2_hit;

    // Only loads stall: non-load EX results are forwarded into the target generator.
    assign rs1_hit = (rs1_addr != 5'd0) &&
                     ((rs1_addr == ex_rd_addr && ex_rd_wr_en && ex_mem_rd) ||
                      (rs1_addr == mem_rd_addr && mem_mem_rd));
    assign rs2_hit = (rs2_addr != 5'd0) &&
                     ((rs2_addr == ex_rd_addr && ex_rd_wr_en && ex_mem_rd) ||
                      (rs2_addr == mem_rd_addr && mem_mem_rd));

    assign hazard = (branch_op != BR_NONE) && (rs1_hit || (is_cond && rs2_hit));
endmodule

// File: rtl/toast_redirect_ctrl.sv
// PC redirect sequencer: load-use stall, trap/branch arbitration, registered redirect held until IF ack.
// Optional statistics counters under `TOAST_BRANCH_STATS_EN (ports tied to 0 otherwise).
module toast_redirect_ctrl
    import toast_redirect_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    toast_redirect_ctrl_if.slave bus
);
    redirect_state_t       state_q, state_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic                  flush_q, flush_d;
    logic                  hazard, jump, stall, id_ex_flush;

    toast_redirect_hazard u_hazard (
        .branch_op   (bus.ID_branch_op_i),
        .is_cond     (bus.ID_is_cond_i),
        .rs1_addr    (bus.ID_rs1_addr_i),
        .rs2_addr    (bus.ID_rs2_addr_i),
        .ex_rd_addr  (bus.EX_rd_addr_i),
        .ex_rd_wr_en (bus.EX_rd_wr_en_i),
        .ex_mem_rd   (bus.EX_mem_rd_i),
        .mem_rd_addr (bus.MEM_rd_addr_i),
        .mem_mem_rd  (bus.MEM_mem_rd_i),
        .hazard      (hazard)
    );

    assign jump = (bus.ID_branch_op_i != BR_NONE) && (!bus.ID_is_cond_i || bus.ID_branch_taken_i);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        flush_d     = 1'b0;
        stall       = 1'b0;
        id_ex_flush = 1'b0;
        case (state_q)
            // HAZ_WAIT re-evaluates exactly like IDLE once operands are ready
            IDLE, HAZ_WAIT: begin
                if (bus.trap_req_i) begin
                    state_d  = REDIRECT;
                    target_d = bus.trap_vec_i;
                    flush_d  = 1'b1;
                end else if (hazard) begin
                    state_d     = HAZ_WAIT;
                    stall       = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (jump) begin
                    state_d  = REDIRECT;
                    target_d = bus.pc_dest_i;
                    flush_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                stall = 1'b1;
                // A trap re-targets the in-flight redirect and masks this cycle's ack
                if (bus.trap_req_i) begin
                    target_d = bus.trap_vec_i;
                    flush_d  = 1'b1;
                end else if (bus.IF_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            target_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.pc_redirect_o = (state_q == REDIRECT);
    assign bus.pc_target_o   = target_q;
    assign bus.IF_ID_flush_o = flush_q;
    // Gate the combinational outputs so reset forces them low immediately
    assign bus.stall_o       = stall && !rst_i;
    assign bus.ID_EX_flush_o = id_ex_flush && !rst_i;

`ifdef TOAST_BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] redirects_q, stall_cycles_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirects_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (flush_d && (redirects_q != '1))
                redirects_q <= redirects_q + 1'b1;
            if (stall && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign bus.stat_redirects_o    = redirects_q;
    assign bus.stat_stall_cycles_o = stall_cycles_q;
`else
    assign bus.stat_redirects_o    = '0;
    assign bus.stat_stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_toast_redirect_ctrl.sv
// Scoreboard bench for toast_redirect_ctrl: directed plan cases then randomized traffic vs. a behavioural model.
module tb_toast_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    toast_redirect_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();

    toast_redirect_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  op;
        logic        cond;
        logic        taken;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  ex_rd;
        logic        ex_we;
        logic        ex_ld;
        logic [4:0]  mem_rd;
        logic        mem_ld;
        logic [31:0] dest;
        logic        trap;
        logic [31:0] vec;
        logic        ack;
    } stim_t;

    typedef struct packed {
        logic        red;
        logic [31:0] tgt;
        logic        stall;
        logic        ifid;
        logic        idex;
        logic [31:0] st_red;
        logic [31:0] st_stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   stim_done = 1'b0;

    // Behavioural model: redirect is either outstanding or not; IDLE and hazard-wait are indistinguishable.
    bit          m_busy   = 1'b0;
    logic [31:0] m_target = '0;
    bit          m_flush  = 1'b0;
    int unsigned m_st_red = 0;
    int unsigned m_st_stall = 0;

    function automatic bit src_blocked(logic [4:0] r, stim_t s);
        if (r == 5'd0) return 1'b0;
        if (r == s.ex_rd && s.ex_we && s.ex_ld) return 1'b1;
        if (r == s.mem_rd && s.mem_ld) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle_stim(bit ack);
        stim_t s;
        s = '0;
        s.ack = ack;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   haz, jmp, stl, nflush;
        @(posedge clk);
        #1;
        rst                   = s.rst;
        bus.ID_branch_op_i    = s.op;
        bus.ID_is_cond_i      = s.cond;
        bus.ID_branch_taken_i = s.taken;
        bus.ID_rs1_addr_i     = s.rs1;
        bus.ID_rs2_addr_i     = s.rs2;
        bus.EX_rd_addr_i      = s.ex_rd;
        bus.EX_rd_wr_en_i     = s.ex_we;
        bus.EX_mem_rd_i       = s.ex_ld;
        bus.MEM_rd_addr_i     = s.mem_rd;
        bus.MEM_mem_rd_i      = s.mem_ld;
        bus.pc_dest_i         = s.dest;
        bus.trap_req_i        = s.trap;
        bus.trap_vec_i        = s.vec;
        bus.IF_ack_i          = s.ack;
        cyc++;

        if (s.rst) begin
            m_busy = 1'b0; m_target = '0; m_flush = 1'b0; m_st_red = 0; m_st_stall = 0;
            e = '0;
            exp_q.push_back(e);
            return;
        end

        haz = (s.op != 2'b00) && (src_blocked(s.rs1, s) || (s.cond && src_blocked(s.rs2, s)));
        jmp = (s.op != 2'b00) && (!s.cond || s.taken);
        stl = m_busy ? 1'b1 : (haz && !s.trap);

        e.red   = m_busy;
        e.tgt   = m_target;
        e.ifid  = m_flush;
        e.stall = stl;
        e.idex  = !m_busy && haz && !s.trap;
`ifdef TOAST_BRANCH_STATS_EN
        e.st_red   = m_st_red;
        e.st_stall = m_st_stall;
`else
        e.st_red   = '0;
        e.st_stall = '0;
`endif
        exp_q.push_back(e);

        nflush = 1'b0;
        if (s.trap) begin
            m_busy = 1'b1; m_target = s.vec; nflush = 1'b1;
        end else if (m_busy) begin
            if (s.ack) m_busy = 1'b0;
        end else if (!haz && jmp) begin
            m_busy = 1'b1; m_target = s.dest; nflush = 1'b1;
        end
        m_flush = nflush;
        if (nflush && m_st_red != 32'hFFFF_FFFF) m_st_red++;
        if (stl && m_st_stall != 32'hFFFF_FFFF) m_st_stall++;
    endtask

    // Monitor: one expected response per cycle, compared mid-cycle.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.red      = bus.pc_redirect_o;
                a.tgt      = bus.pc_target_o;
                a.stall    = bus.stall_o;
                a.ifid     = bus.IF_ID_flush_o;
                a.idex     = bus.ID_EX_flush_o;
                a.st_red   = bus.stat_redirects_o;
                a.st_stall = bus.stat_stall_cycles_o;
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle%0d outputs: got red=%0b tgt=%h stall=%0b ifid=%0b idex=%0b sr=%0d ss=%0d; want red=%0b tgt=%h stall=%0b ifid=%0b idex=%0b sr=%0d ss=%0d",
                             cyc, a.red, a.tgt, a.stall, a.ifid, a.idex, a.st_red, a.st_stall,
                             e.red, e.tgt, e.stall, e.ifid, e.idex, e.st_red, e.st_stall);
                end
            end
        end
    end

    initial begin
        stim_t s;
        bus.ID_branch_op_i = '0; bus.ID_is_cond_i = 1'b0; bus.ID_branch_taken_i = 1'b0;
        bus.ID_rs1_addr_i = '0; bus.ID_rs2_addr_i = '0; bus.EX_rd_addr_i = '0;
        bus.EX_rd_wr_en_i = 1'b0; bus.EX_mem_rd_i = 1'b0; bus.MEM_rd_addr_i = '0;
        bus.MEM_mem_rd_i = 1'b0; bus.pc_dest_i = '0; bus.trap_req_i = 1'b0;
        bus.trap_vec_i = '0; bus.IF_ack_i = 1'b0;

        s = idle_stim(1'b0); s.rst = 1'b1;
        step(s); step(s);
        step(idle_stim(1'b0));

        // JAL with IF ack tied high
        s = idle_stim(1'b1); s.op = 2'b01; s.dest = 32'h100;
        step(s);
        step(idle_stim(1'b1)); step(idle_stim(1'b1));

        // JALR waiting on EX load then MEM load of x5
        s = idle_stim(1'b1); s.op = 2'b10; s.rs1 = 5'd5; s.dest = 32'h2000;
        s.ex_rd = 5'd5; s.ex_we = 1'b1; s.ex_ld = 1'b1;
        step(s);
        s.ex_rd = 5'd0; s.ex_we = 1'b0; s.ex_ld = 1'b0; s.mem_rd = 5'd5; s.mem_ld = 1'b1;
        step(s);
        s.mem_rd = 5'd0; s.mem_ld = 1'b0;
        step(s);
        step(idle_stim(1'b1)); step(idle_stim(1'b1));

        // Not-taken branch against a non-load EX producer
        s = idle_stim(1'b1); s.op = 2'b01; s.cond = 1'b1; s.rs2 = 5'd7;
        s.ex_rd = 5'd7; s.ex_we = 1'b1; s.dest = 32'h444;
        step(s); step(idle_stim(1'b1));

        // Simultaneous trap and JAL
        s = idle_stim(1'b1); s.op = 2'b01; s.dest = 32'h40; s.trap = 1'b1; s.vec = 32'h80;
        step(s);
        step(idle_stim(1'b1)); step(idle_stim(1'b1));

        // Trap re-targets a redirect stuck waiting for ack
        s = idle_stim(1'b0); s.op = 2'b01; s.dest = 32'h300;
        step(s);
        step(idle_stim(1'b0)); step(idle_stim(1'b0)); step(idle_stim(1'b0));
        s = idle_stim(1'b1); s.trap = 1'b1; s.vec = 32'h80;
        step(s);
        step(idle_stim(1'b0)); step(idle_stim(1'b1)); step(idle_stim(1'b0));

        // Async reset mid-redirect, then x0 never hazards
        s = idle_stim(1'b0); s.op = 2'b01; s.dest = 32'h500;
        step(s); step(idle_stim(1'b0));
        s = idle_stim(1'b0); s.rst = 1'b1;
        step(s);
        step(idle_stim(1'b0));
        s = idle_stim(1'b1); s.op = 2'b10; s.rs1 = 5'd0; s.dest = 32'h600;
        s.ex_rd = 5'd0; s.ex_we = 1'b1; s.ex_ld = 1'b1;
        step(s);
        step(idle_stim(1'b1)); step(idle_stim(1'b0));

        // Randomized traffic; small register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            s.rst    = ($urandom_range(0, 99) == 0);
            s.op     = 2'($urandom_range(0, 3));
            s.cond   = 1'($urandom_range(0, 1));
            s.taken  = 1'($urandom_range(0, 1));
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.ex_we  = 1'($urandom_range(0, 1));
            s.ex_ld  = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.mem_ld = ($urandom_range(0, 2) == 0);
            s.dest   = $urandom;
            s.trap   = ($urandom_range(0, 9) == 0);
            s.vec    = $urandom;
            s.ack    = ($urandom_range(0, 2) != 0);
            step(s);
        end
        step(idle_stim(1'b1));
        stim_done = 1'b1;
    end

    initial begin
        int guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        n_tests++;
        if (!stim_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got done=%0b pending=%0d, want done=1 pending=0", stim_done, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/toast_redirect_ctrl.md
Name: toast_redirect_ctrl

Overview:
- Sequences PC redirection for the RV32I pipeline; sits between ID-stage branch target generation, the trap logic and the IF stage.
- Detects load-use hazards on branch/jump source registers, then stalls ID and bubbles EX until operands are valid.
- Issues a registered redirect (target + flush) and holds it until IF acknowledges.
- Arbitrates between branch/jump redirects and trap redirects; traps win.

Parameters:
- DATA_WIDTH, 32, width of PC/target buses.
- CNT_WIDTH, 32, width of statistics counters (only with TOAST_BRANCH_STATS_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ID_branch_op_i  in  2  [1]=JALR (reg-offset), [0]=JAL/cond (pc-relative); 00=none
- ID_is_cond_i  in  1  ID instruction is a conditional branch (uses rs2)
- ID_branch_taken_i  in  1  condition outcome; ignored unless ID_is_cond_i
- ID_rs1_addr_i, ID_rs2_addr_i  in  5 each  ID source registers
- EX_rd_addr_i  in  5  EX destination
- EX_rd_wr_en_i  in  1  EX writes rd
- EX_mem_rd_i  in  1  EX instruction is a load
- MEM_rd_addr_i  in  5  MEM destination
- MEM_mem_rd_i  in  1  MEM instruction is a load (writes rd)
- pc_dest_i  in  DATA_WIDTH  target from branch target generator
- trap_req_i  in  1  trap redirect request (single-cycle pulse)
- trap_vec_i  in  DATA_WIDTH  trap target
- IF_ack_i  in  1  IF has accepted the redirect
- pc_redirect_o  out  1  redirect valid
- pc_target_o  out  DATA_WIDTH  redirect target
- stall_o  out  1  hold PC and IF/ID register
- IF_ID_flush_o  out  1  kill IF/ID contents
- ID_EX_flush_o  out  1  insert bubble into ID/EX
- stat_redirects_o, stat_stall_cycles_o  out  CNT_WIDTH  statistics (macro only)

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-operation drops any pending redirect.
- "jump" means op!=00 and (!ID_is_cond_i or ID_branch_taken_i).
- Combinational hazard detect when op!=00 and any of the following holds:
  - rs1==EX_rd_addr_i, EX_rd_wr_en_i && EX_mem_rd_i;
  - rs1==MEM_rd_addr_i && MEM_mem_rd_i;
  - ID_is_cond_i and rs2 matches under the same two conditions.
  - A register address of 0 never raises a hazard.
- A non-load EX producer is not a hazard: the branch target generator forwards from the EX ALU result.
- States: IDLE, HAZ_WAIT, REDIRECT.
- IDLE:
  - trap_req_i: latch trap_vec_i, go to REDIRECT.
  - Else hazard: go to HAZ_WAIT; stall_o=1 and ID_EX_flush_o=1 combinationally in the same cycle.
  - Else jump: latch pc_dest_i, go to REDIRECT.
- HAZ_WAIT:
  - stall_o=1 and ID_EX_flush_o=1 while the hazard persists.
  - When the hazard clears, evaluate as in IDLE in that cycle; the latch happens in the clear cycle.
  - trap_req_i aborts the wait and goes to REDIRECT with the trap target.
- REDIRECT:
  - pc_redirect_o=1 and pc_target_o is the latched target, both registered.
  - IF_ID_flush_o=1 in the first REDIRECT cycle only.
  - stall_o=1 until IF_ack_i is sampled high.
  - On ack: return to IDLE; outputs drop the next cycle.
  - trap_req_i while in REDIRECT: overwrite the target with trap_vec_i, re-pulse IF_ID_flush_o, stay in REDIRECT; any pending ack that cycle is ignored.
- Latency: jump resolved in ID at cycle N gives pc_redirect_o at N+1. Minimum redirect penalty is 1 cycle when IF_ack_i is high at N+1.
- Simultaneous trap and jump: trap wins; the jump is discarded.
- Branch not taken: no state change, no flush.
- pc_target_o holds its last value when pc_redirect_o=0.

Optional Feature:
- Macro: TOAST_BRANCH_STATS_EN.
- Defined:
  - stat_redirects_o counts REDIRECT entries, trap overwrites included.
  - stat_stall_cycles_o counts cycles with stall_o=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are still present and tied to 0; the counters are not synthesised.

Decomposition:
- Shared definitions header holds:
  - the state encodings;
  - the branch-op encodings PC_RELATIVE=2'b01 and REG_OFFSET=2'b10, alongside the existing ones.
- One natural sub-module, toast_redirect_hazard: purely combinational hazard-detect logic, instantiated once.

Test Plan:
- JAL, op=01, pc_dest_i=0x100, IF_ack_i tied high → pc_redirect_o=1 with pc_target_o=0x100 at N+1, IF_ID_flush_o pulses once, IDLE at N+2.
- JALR with rs1=5, EX load with rd=5, then MEM load with rd=5 → stall_o and ID_EX_flush_o high for 2 cycles, then redirect to pc_dest_i=0x2000.
- Conditional branch, ID_is_cond_i=1, ID_branch_taken_i=0, rs2 matching a non-load EX producer → no stall, no redirect, no flush.
- Trap (vec 0x80) and JAL (0x40) in the same cycle → target 0x80 only; stat_redirects_o increments by 1.
- In REDIRECT with IF_ack_i low for 3 cycles, then trap 0x80 → target changes to 0x80, IF_ID_flush_o re-pulses, exit after ack.
- Assert rst_i asynchronously mid-REDIRECT → all outputs 0 immediately, IDLE after release; rs1=0 against an EX load with rd=0 → no stall.
